// File: rtl/ud_pkg.sv
// Shared constants and state encoding for the up/down counter capture buffer.
package ud_pkg;

  localparam logic [1:0] ADDR_CTRL  = 2'b00;
  localparam logic [1:0] ADDR_DIR   = 2'b01;
  localparam logic [1:0] ADDR_STAT  = 2'b10;
  localparam logic [1:0] ADDR_DECIM = 2'b11;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_CLR     = 1;
  localparam int CTRL_EC_STOP = 2;

  localparam int STAT_OVERFLOW = 7;
  localparam int STAT_ERR_SEEN = 6;
  localparam int STAT_EC_SEEN  = 5;
  localparam int STAT_FULL     = 4;
  localparam int STAT_EMPTY    = 3;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/ud_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is taken only alongside a pop,
// and clear overrides any concurrent push or pop.
module ud_sync_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [LW-1:0] level_q;
  logic          doPush, doPop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign doPush  = push_i & (~full_o | pop_i);
  assign doPop   = pop_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else if (clr_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      level_q <= level_q + LW'(doPush) - LW'(doPop);
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/ud_count_capture.sv
// Capture buffer for the up/down counter: records {dir, cout} during a run,
// optionally decimated, and exposes it on the counter's 4-register CPU bus.
module ud_count_capture
  import ud_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] cout_i,
  input  logic          dir_i,
  input  logic          ec_i,
  input  logic          err_i,
  input  logic          start_i,
  input  logic          ncs_i,
  input  logic          nrd_i,
  input  logic          nwr_i,
  input  logic          a0_i,
  input  logic          a1_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          dout_oe_o,
  output logic          irq_o
);

  localparam int LW = $clog2(DEPTH) + 1;

  state_e        state_q, state_d;
  logic          en_q, ecStop_q;
  logic [DW-1:0] decim_q, decimCnt_q, decimCnt_d;
  logic          rdHead_q;
  logic          overflow_q, errSeen_q, ecSeen_q;

  logic [1:0]    addr;
  logic          wrEn, ctrlWr, decimWr, clr, enNew;
  logic          push, pop;
  logic [DW:0]   head;
  logic          full, empty;
  logic [LW-1:0] level;
  logic [7:0]    status;

  assign addr      = {a1_i, a0_i};
  assign wrEn      = ~ncs_i & ~nwr_i;
  assign dout_oe_o = ~ncs_i & ~nrd_i & nwr_i;
  assign ctrlWr    = wrEn & (addr == ADDR_CTRL);
  assign decimWr   = wrEn & (addr == ADDR_DECIM);
  assign clr       = ctrlWr & din_i[CTRL_CLR];
  assign enNew     = ctrlWr ? din_i[CTRL_EN] : en_q;

  // The end-of-count cycle is always kept so the trajectory ends on its true final value.
  assign push = (state_q == RUN) & en_q & ((decimCnt_q == '0) | ec_i);
  // A head read pops once, at the first edge after the read strobe is gone.
  assign pop  = rdHead_q & ~dout_oe_o;

  ud_sync_fifo #(
    .W     (DW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({dir_i, cout_i}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = enNew ? ARMED : IDLE;
    end else if (!en_q) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = ARMED;
        ARMED:   if (start_i) state_d = RUN;
        RUN:     if (ec_i && ecStop_q) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Outside RUN the counter sits at zero, so every run starts with a capture.
  always_comb begin
    decimCnt_d = '0;
    if (state_q == RUN) begin
      decimCnt_d = (decimCnt_q == decim_q) ? '0 : decimCnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      en_q       <= 1'b0;
      ecStop_q   <= 1'b0;
      decim_q    <= '0;
      decimCnt_q <= '0;
      rdHead_q   <= 1'b0;
      overflow_q <= 1'b0;
      errSeen_q  <= 1'b0;
      ecSeen_q   <= 1'b0;
    end else begin
      if (ctrlWr) begin
        en_q     <= din_i[CTRL_EN];
        ecStop_q <= din_i[CTRL_EC_STOP];
      end
      if (decimWr) decim_q <= din_i;
      decimCnt_q <= decimCnt_d;
      rdHead_q   <= dout_oe_o & (addr == ADDR_CTRL);
      if (clr) begin
        overflow_q <= 1'b0;
        errSeen_q  <= 1'b0;
        ecSeen_q   <= 1'b0;
      end else begin
        if (push & full & ~pop) overflow_q <= 1'b1;
        if (err_i && (state_q == ARMED || state_q == RUN)) errSeen_q <= 1'b1;
        if (ec_i && state_q == RUN) ecSeen_q <= 1'b1;
      end
    end
  end

  always_comb begin
    status                = '0;
    status[STAT_OVERFLOW] = overflow_q;
    status[STAT_ERR_SEEN] = errSeen_q;
    status[STAT_EC_SEEN]  = ecSeen_q;
    status[STAT_FULL]     = full;
    status[STAT_EMPTY]    = empty;
    status[2:0]           = 3'(level);
  end

  always_comb begin
    dout_o = '0;
    if (dout_oe_o) begin
      unique case (addr)
        ADDR_CTRL:  dout_o = head[DW-1:0];
        ADDR_DIR:   dout_o = DW'(head[DW]);
        ADDR_STAT:  dout_o = DW'(status);
        ADDR_DECIM: dout_o = decim_q;
        default:    dout_o = '0;
      endcase
    end
  end

  assign irq_o = ecSeen_q | overflow_q;

endmodule

// File: tb/tb_ud_count_capture.sv
// Directed bench for ud_count_capture: hand-computed captures, flags and bus reads.
module tb_ud_count_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cout;
  logic       dir, ec, err, start;
  logic       ncs, nrd, nwr, a0, a1;
  logic [7:0] din;
  logic [7:0] dout;
  logic       doutOe, irq;

  int checks = 0;
  int errors = 0;

  logic [7:0] rdVal;
  logic [7:0] expVal1 [4] = '{8'h03, 8'h04, 8'h03, 8'h02};
  logic [7:0] expDir1 [4] = '{8'h01, 8'h01, 8'h00, 8'h00};
  logic [7:0] expVal2 [4] = '{8'h00, 8'h03, 8'h06, 8'h08};

  ud_count_capture #(.DW(8), .DEPTH(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .cout_i    (cout),
    .dir_i     (dir),
    .ec_i      (ec),
    .err_i     (err),
    .start_i   (start),
    .ncs_i     (ncs),
    .nrd_i     (nrd),
    .nwr_i     (nwr),
    .a0_i      (a0),
    .a1_i      (a1),
    .din_i     (din),
    .dout_o    (dout),
    .dout_oe_o (doutOe),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] c, input logic d, input logic e,
                               input logic r, input logic s);
    cout  = c;
    dir   = d;
    ec    = e;
    err   = r;
    start = s;
    tick();
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [7:0] data);
    {a1, a0} = addr;
    din = data;
    ncs = 1'b0;
    nwr = 1'b0;
    tick();
    ncs = 1'b1;
    nwr = 1'b1;
  endtask

  // Two clocks: one with the strobe held, one idle so a head read pops.
  task automatic busRead(input logic [1:0] addr, output logic [7:0] data);
    {a1, a0} = addr;
    ncs = 1'b0;
    nrd = 1'b0;
    #1;
    data = dout;
    tick();
    ncs = 1'b1;
    nrd = 1'b1;
    tick();
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; cout = '0; dir = 1'b0; ec = 1'b0; err = 1'b0; start = 1'b0;
    ncs = 1'b1; nrd = 1'b1; nwr = 1'b1; a0 = 1'b0; a1 = 1'b0; din = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    checkOutput("reset dout_oe", {7'b0, doutOe}, 8'h00);
    checkOutput("reset dout", dout, 8'h00);
    checkOutput("reset irq", {7'b0, irq}, 8'h00);
    busRead(2'b10, rdVal); checkOutput("reset status", rdVal, 8'h08);
    busRead(2'b11, rdVal); checkOutput("reset decim", rdVal, 8'h00);

    // Basic run 3,4,3,2 with end-of-count stop
    busWrite(2'b00, 8'h05);
    tick();
    applyStimulus(8'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("run1 irq", {7'b0, irq}, 8'h01);
    busRead(2'b10, rdVal); checkOutput("run1 status", rdVal, 8'h24);
    for (int i = 0; i < 4; i++) begin
      busRead(2'b01, rdVal); checkOutput($sformatf("run1 dir%0d", i), rdVal, expDir1[i]);
      busRead(2'b00, rdVal); checkOutput($sformatf("run1 val%0d", i), rdVal, expVal1[i]);
    end
    busRead(2'b10, rdVal); checkOutput("run1 drained status", rdVal, 8'h28);
    busWrite(2'b00, 8'h03);
    busRead(2'b10, rdVal); checkOutput("run1 clr status", rdVal, 8'h08);
    checkOutput("run1 clr irq", {7'b0, irq}, 8'h00);

    // Decimation by 3 over cout 0..8 with end-of-count on 8
    busWrite(2'b00, 8'h05);
    busWrite(2'b11, 8'h02);
    busRead(2'b11, rdVal); checkOutput("decim readback", rdVal, 8'h02);
    applyStimulus(8'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(8'(i), 1'b1, (i == 8), 1'b0, 1'b0);
    applyStimulus(8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    busRead(2'b10, rdVal); checkOutput("decim status", rdVal, 8'h24);
    for (int i = 0; i < 4; i++) begin
      busRead(2'b00, rdVal); checkOutput($sformatf("decim val%0d", i), rdVal, expVal2[i]);
    end
    busWrite(2'b11, 8'h00);
    busWrite(2'b00, 8'h07);

    // Ten samples into eight entries
    applyStimulus(8'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) applyStimulus(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    busWrite(2'b00, 8'h04);
    busRead(2'b10, rdVal); checkOutput("ovf status", rdVal, 8'h90);
    checkOutput("ovf irq", {7'b0, irq}, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      busRead(2'b00, rdVal); checkOutput($sformatf("ovf pop%0d", i), rdVal, 8'(i));
    end
    busRead(2'b00, rdVal); checkOutput("ovf pop empty", rdVal, 8'h00);
    busRead(2'b10, rdVal); checkOutput("ovf empty status", rdVal, 8'h88);
    busWrite(2'b00, 8'h07);
    busRead(2'b10, rdVal); checkOutput("ovf clr status", rdVal, 8'h08);

    // Held head read pops once; peek does not pop
    applyStimulus(8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    busRead(2'b10, rdVal); checkOutput("hold status", rdVal, 8'h22);
    busRead(2'b01, rdVal); checkOutput("hold peek before", rdVal, 8'h01);
    busRead(2'b01, rdVal); checkOutput("hold peek again", rdVal, 8'h01);
    {a1, a0} = 2'b00;
    ncs = 1'b0;
    nrd = 1'b0;
    #1;
    checkOutput("hold oe", {7'b0, doutOe}, 8'h01);
    checkOutput("hold dout0", dout, 8'h11);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput($sformatf("hold dout%0d", k), dout, 8'h11);
    end
    ncs = 1'b1;
    nrd = 1'b1;
    tick();
    busRead(2'b01, rdVal); checkOutput("hold peek after", rdVal, 8'h00);
    busRead(2'b10, rdVal); checkOutput("hold level after", rdVal, 8'h21);
    busRead(2'b00, rdVal); checkOutput("hold next head", rdVal, 8'h22);
    busRead(2'b10, rdVal); checkOutput("hold drained", rdVal, 8'h28);

    // err mid-run, then clear and rearm
    busWrite(2'b00, 8'h07);
    busRead(2'b10, rdVal); checkOutput("err pre status", rdVal, 8'h08);
    applyStimulus(8'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    busRead(2'b10, rdVal); checkOutput("err status", rdVal, 8'h63);
    busWrite(2'b00, 8'h07);
    busRead(2'b10, rdVal); checkOutput("err clr status", rdVal, 8'h08);
    checkOutput("err clr irq", {7'b0, irq}, 8'h00);
    applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h5B, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    busRead(2'b10, rdVal); checkOutput("rearm status", rdVal, 8'h22);
    busRead(2'b00, rdVal); checkOutput("rearm head", rdVal, 8'h5A);

    // Reset during a run with five entries
    busWrite(2'b00, 8'h07);
    applyStimulus(8'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("rst dout_oe", {7'b0, doutOe}, 8'h00);
    checkOutput("rst irq", {7'b0, irq}, 8'h00);
    busRead(2'b10, rdVal); checkOutput("rst status", rdVal, 8'h08);
    applyStimulus(8'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    busRead(2'b10, rdVal); checkOutput("rst no capture", rdVal, 8'h08);
    busWrite(2'b00, 8'h05);
    tick();
    applyStimulus(8'h33, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h33, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    busRead(2'b10, rdVal); checkOutput("rst rearm status", rdVal, 8'h21);
    busRead(2'b00, rdVal); checkOutput("rst rearm head", rdVal, 8'h33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
